// File: rtl/tetris_input_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// enum_type : shared types for the tetris game core and its input arbiter.
//
//   state_type  - game core state; the same encoding is used for the command
//                 stream (NONE / LEFT / ... / BAR) that drives the core.
//   BTN_*       - bit positions inside the 7-bit debounced button vector.
//   PRIO_ORDER  - button command priority, highest first. DOWN also carries
//                 the gravity request; BAR ranks below every button.
//   REP_BTN     - buttons that auto-repeat when TETRIS_AUTO_REPEAT_EN is set.
//   btn_cmd()   - maps a button index to its command value.
//   imax()      - integer max, used for elaboration-time widths.
// ---------------------------------------------------------------------------
package enum_type;

    typedef enum logic [4:0] {
        NONE,
        LEFT,
        RIGHT,
        ROTATE,
        ROTATE_REV,
        DOWN,
        DROP,
        HOLD,
        BAR,
        INIT,
        GEN,
        WAIT,
        CHECK_MOVE,
        CHECK_ROT,
        CHECK_LINE,
        CLEAR,
        BPLACE,
        END
    } state_type;

    localparam int NUM_BTN        = 7;
    localparam int BTN_LEFT       = 0;
    localparam int BTN_RIGHT      = 1;
    localparam int BTN_ROTATE     = 2;
    localparam int BTN_ROTATE_REV = 3;
    localparam int BTN_DOWN       = 4;
    localparam int BTN_DROP       = 5;
    localparam int BTN_HOLD       = 6;

    localparam int PRIO_ORDER [NUM_BTN] = '{
        BTN_HOLD, BTN_ROTATE, BTN_ROTATE_REV, BTN_LEFT,
        BTN_RIGHT, BTN_DROP, BTN_DOWN
    };

    localparam int NUM_REP = 3;
    localparam int REP_BTN [NUM_REP] = '{BTN_LEFT, BTN_RIGHT, BTN_DOWN};

    function automatic state_type btn_cmd(input int idx);
        state_type cmd;
        case (idx)
            BTN_LEFT:       cmd = LEFT;
            BTN_RIGHT:      cmd = RIGHT;
            BTN_ROTATE:     cmd = ROTATE;
            BTN_ROTATE_REV: cmd = ROTATE_REV;
            BTN_DOWN:       cmd = DOWN;
            BTN_DROP:       cmd = DROP;
            BTN_HOLD:       cmd = HOLD;
            default:        cmd = NONE;
        endcase
        return cmd;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tetris_input_arbiter_ms_tick.sv
// ---------------------------------------------------------------------------
// ms_tick : free-running millisecond strobe.
//
//   clk    in   system clock
//   reset  in   asynchronous active-high reset
//   tick   out  one-cycle pulse every CLK_HZ/1000 clocks
//
// With CLK_HZ=1000 the divider is 1 and tick is high on every cycle after
// the first clock following reset.
// ---------------------------------------------------------------------------
module ms_tick #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int DIV = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;
    logic          wrap;

    always_comb begin
        wrap   = (cnt_q == CW'(DIV - 1));
        cnt_d  = wrap ? '0 : cnt_q + 1'b1;
        tick_d = wrap;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/tetris_input_arbiter.sv
// ---------------------------------------------------------------------------
// tetris_input_arbiter : merges player buttons, gravity and garbage-row
// requests into a single command per WAIT visit of the game core.
//
//   clk            in   system clock
//   reset          in   asynchronous active-high reset
//   btn[6:0]       in   debounced levels (LEFT,RIGHT,ROTATE,ROTATE_REV,
//                       DOWN,DROP,HOLD from bit 0 upwards)
//   game_state     in   game core state
//   score[15:0]    in   4-digit BCD score; thousands/hundreds set the level
//   garbage_valid  in   garbage row requested
//   garbage_hole   in   hole column 0..9, larger values clamp to 9
//   garbage_ready  out  request accepted on a cycle with valid & ready
//   ctrl           out  one-cycle command to the game core
//   bar_mask[9:0]  out  hole mask, non-zero only while ctrl == BAR
//   level[3:0]     out  gravity level
//
// Optional build macro TETRIS_AUTO_REPEAT_EN: LEFT/RIGHT/DOWN re-arm their
// pending bit after DAS_MS of holding and every ARR_MS thereafter.
// ---------------------------------------------------------------------------
module tetris_input_arbiter
    import enum_type::*;
#(
    parameter int CLK_HZ          = 100_000_000,
    parameter int GRAVITY_BASE_MS = 1000,
    parameter int GRAVITY_STEP_MS = 60,
    parameter int GRAVITY_MIN_MS  = 100,
    parameter int DAS_MS          = 170,
    parameter int ARR_MS          = 50
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [6:0]        btn,
    input  state_type         game_state,
    input  logic [15:0]       score,
    input  logic              garbage_valid,
    input  logic [3:0]        garbage_hole,
    output logic              garbage_ready,
    output state_type         ctrl,
    output logic [9:0]        bar_mask,
    output logic [3:0]        level
);

    // One width for every millisecond counter in this block.
    localparam int MS_MAX = imax(imax(GRAVITY_BASE_MS, GRAVITY_MIN_MS), DAS_MS + ARR_MS);
    localparam int MS_W   = $clog2(MS_MAX + 1);

    logic tick;

    ms_tick #(.CLK_HZ(CLK_HZ)) u_ms_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Registers
    logic [6:0]      btn_prev_q, btn_prev_d;
    logic [6:0]      pend_q, pend_d;
    logic            grav_pend_q, grav_pend_d;
    logic [MS_W-1:0] grav_ms_q, grav_ms_d;
    logic            bar_pend_q, bar_pend_d;
    logic [9:0]      bar_r_q, bar_r_d;
    state_type       ctrl_q, ctrl_d;
    logic [9:0]      bar_mask_q, bar_mask_d;
    logic [3:0]      level_q, level_d;
    logic            wait_done_q, wait_done_d;

    // Combinational helpers
    logic [6:0]      rise;
    logic [6:0]      rep_ev;
    logic [6:0]      req;
    logic [6:0]      clr;
    logic            win_found;
    logic [2:0]      win_idx;
    logic            idle_st;
    logic            can_issue;
    logic            grav_clr;
    logic [MS_W-1:0] grav_base;
    logic [MS_W-1:0] grav_nxt;
    logic [MS_W-1:0] period_ms;
    int              period_i;
    logic [7:0]      lv_sum;
    logic [3:0]      hole_c;

    // Low score digits do not affect pacing.
    logic score_unused;
    assign score_unused = ^score[7:0];

    // Level from the BCD thousands/hundreds digits, saturating at 15.
    always_comb begin
        lv_sum  = 8'(score[15:12]) * 8'd10 + 8'(score[11:8]);
        level_d = (lv_sum > 8'd15) ? 4'd15 : lv_sum[3:0];
    end

    // Gravity period in signed arithmetic so a large level cannot wrap.
    always_comb begin
        period_i = GRAVITY_BASE_MS - int'(level_q) * GRAVITY_STEP_MS;
        if (period_i < GRAVITY_MIN_MS) begin
            period_i = GRAVITY_MIN_MS;
        end
        period_ms = MS_W'(period_i);
    end

`ifdef TETRIS_AUTO_REPEAT_EN
    // Per-button hold timers. Counting starts with the press; the first
    // repeat fires at DAS_MS and the counter then cycles DAS..DAS+ARR.
    logic [MS_W-1:0] rep_cnt_q [NUM_REP];
    logic [MS_W-1:0] rep_cnt_d [NUM_REP];

    always_comb begin
        logic [MS_W-1:0] rep_nxt;
        rep_ev  = '0;
        rep_nxt = '0;
        for (int k = 0; k < NUM_REP; k++) begin
            rep_cnt_d[k] = rep_cnt_q[k];
            rep_nxt      = rep_cnt_q[k] + 1'b1;
            if (!btn[REP_BTN[k]]) begin
                rep_cnt_d[k] = '0;
            end else if (tick) begin
                if (rep_nxt == MS_W'(DAS_MS)) begin
                    rep_ev[REP_BTN[k]] = 1'b1;
                    rep_cnt_d[k]       = rep_nxt;
                end else if (rep_nxt == MS_W'(DAS_MS + ARR_MS)) begin
                    rep_ev[REP_BTN[k]] = 1'b1;
                    rep_cnt_d[k]       = MS_W'(DAS_MS);
                end else begin
                    rep_cnt_d[k] = rep_nxt;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_REP; k++) begin
                rep_cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_REP; k++) begin
                rep_cnt_q[k] <= rep_cnt_d[k];
            end
        end
    end
`else
    assign rep_ev = '0;
`endif

    // Garbage handshake: a request transfers on any cycle where
    // garbage_valid and garbage_ready are both high; ready is low exactly
    // while an accepted row is still waiting to be issued as BAR, so the
    // requester must hold valid/hole stable until it sees ready.
    assign garbage_ready = !bar_pend_q;

    always_comb begin
        btn_prev_d  = btn;
        pend_d      = pend_q;
        grav_pend_d = grav_pend_q;
        grav_ms_d   = grav_ms_q;
        bar_pend_d  = bar_pend_q;
        bar_r_d     = bar_r_q;
        ctrl_d      = NONE;
        bar_mask_d  = '0;
        wait_done_d = wait_done_q;
        clr         = '0;
        req         = '0;
        win_found   = 1'b0;
        win_idx     = '0;
        grav_clr    = 1'b0;
        grav_base   = '0;
        grav_nxt    = '0;

        rise      = btn & ~btn_prev_q;
        hole_c    = (garbage_hole > 4'd9) ? 4'd9 : garbage_hole;
        idle_st   = (game_state == INIT) || (game_state == END);
        // wait_done_q limits the core to one command per WAIT entry.
        can_issue = (game_state == WAIT) && (ctrl_q == NONE) && !wait_done_q;

        if (idle_st) begin
            // Any press just nudges the core out of INIT/END. Everything
            // queued is dropped, including a garbage row accepted now.
            pend_d      = '0;
            bar_pend_d  = 1'b0;
            grav_pend_d = 1'b0;
            grav_ms_d   = '0;
            wait_done_d = 1'b0;
            if (|rise) begin
                ctrl_d = DOWN;
            end
        end else begin
            if (game_state != WAIT) begin
                wait_done_d = 1'b0;
            end

            if (garbage_valid && !bar_pend_q) begin
                bar_pend_d = 1'b1;
                bar_r_d    = 10'd1 << (4'd9 - hole_c);
            end

            if (can_issue) begin
                req           = pend_q;
                req[BTN_DOWN] = pend_q[BTN_DOWN] | grav_pend_q;
                // Walk from lowest to highest priority so the highest wins.
                for (int p = NUM_BTN - 1; p >= 0; p--) begin
                    if (req[PRIO_ORDER[p]]) begin
                        win_found = 1'b1;
                        win_idx   = 3'(PRIO_ORDER[p]);
                    end
                end
                if (win_found) begin
                    ctrl_d       = btn_cmd(int'(win_idx));
                    clr[win_idx] = 1'b1;
                    wait_done_d  = 1'b1;
                    if ((int'(win_idx) == BTN_DOWN) || (int'(win_idx) == BTN_DROP)) begin
                        grav_clr = 1'b1;
                    end
                end else if (bar_pend_q) begin
                    ctrl_d      = BAR;
                    bar_mask_d  = bar_r_q;
                    bar_pend_d  = 1'b0;
                    wait_done_d = 1'b1;
                end
            end

            // A fresh edge in the issue cycle re-arms the bit it clears.
            pend_d = (pend_q & ~clr) | rise | rep_ev;

            // The tick of the restart cycle counts as the first tick of the
            // new period, so DOWN pulses land exactly period_ms apart.
            grav_base = grav_clr ? '0 : grav_ms_q;
            grav_nxt  = grav_base + 1'b1;
            if (grav_clr) begin
                grav_pend_d = 1'b0;
            end
            if (tick) begin
                if (grav_nxt >= period_ms) begin
                    grav_ms_d   = '0;
                    grav_pend_d = 1'b1;
                end else begin
                    grav_ms_d = grav_nxt;
                end
            end else begin
                grav_ms_d = grav_base;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_prev_q  <= '0;
            pend_q      <= '0;
            grav_pend_q <= 1'b0;
            grav_ms_q   <= '0;
            bar_pend_q  <= 1'b0;
            bar_r_q     <= '0;
            ctrl_q      <= NONE;
            bar_mask_q  <= '0;
            level_q     <= '0;
            wait_done_q <= 1'b0;
        end else begin
            btn_prev_q  <= btn_prev_d;
            pend_q      <= pend_d;
            grav_pend_q <= grav_pend_d;
            grav_ms_q   <= grav_ms_d;
            bar_pend_q  <= bar_pend_d;
            bar_r_q     <= bar_r_d;
            ctrl_q      <= ctrl_d;
            bar_mask_q  <= bar_mask_d;
            level_q     <= level_d;
            wait_done_q <= wait_done_d;
        end
    end

    assign ctrl     = ctrl_q;
    assign bar_mask = bar_mask_q;
    assign level    = level_q;

endmodule
